// File: rtl/seg7_cmd_ctrl_if.sv
// UART-side byte stream for the 7-segment command controller.
// master = UART/host side, slave = controller side.
interface seg7_cmd_ctrl_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output rx_data, rx_valid, tx_ready, input tx_data, tx_valid);
    modport slave  (input rx_data, rx_valid, tx_ready, output tx_data, tx_valid);
endinterface

// File: rtl/seg7_cmd_ctrl.sv
// ASCII command parser driving a 4-digit multiplexed 7-segment display.
// Commands: "Dhhhh\n" sets the digits, "Bh\n" sets brightness, "C\n" clears.
// Each command is acknowledged with 'K' (accepted) or 'E' (rejected).
module seg7_cmd_ctrl #(
    parameter int SCAN_DIV    = 7500,
    parameter int TIMEOUT_CYC = 3000000
) (
    input  logic               i_clk,
    input  logic               i_reset,
    seg7_cmd_ctrl_if.slave     bus,
    output logic [6:0]         o_seg,
    output logic [3:0]         o_an,
    output logic               o_busy,
    output logic               o_err
);
    localparam int SW = (SCAN_DIV > 1)    ? $clog2(SCAN_DIV)    : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    localparam logic [7:0] CH_D  = 8'h44;
    localparam logic [7:0] CH_B  = 8'h42;
    localparam logic [7:0] CH_C  = 8'h43;
    localparam logic [7:0] CH_K  = 8'h4B;
    localparam logic [7:0] CH_E  = 8'h45;
    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;

    typedef enum logic [1:0] {S_IDLE, S_GET_HEX, S_GET_LF, S_SEND} state_t;

    state_t          r_state, w_state_nx;
    logic [7:0]      r_cmd;
    logic [2:0]      r_left;
    logic [15:0]     r_stage;
    logic [TW-1:0]   r_tmo;
    logic [7:0]      r_tx_data;
    logic            r_err;
    logic [15:0]     r_disp;
    logic [3:0]      r_bright;
    logic [SW-1:0]   r_scan;
    logic [1:0]      r_dig;
    logic [3:0]      r_pwm;
    logic [6:0]      r_seg;
    logic [3:0]      r_an;

    logic            w_is_hex;
    logic [3:0]      w_nib;
    logic            w_tmo_hit;
    logic            w_send;
    logic [7:0]      w_ack;
    logic            w_tmo_clr;
    logic            w_start;
    logic [2:0]      w_need;
    logic            w_shift;
    logic            w_commit;
    logic            w_cmd_ld;
    logic [3:0]      w_sel_nib;
    logic [6:0]      w_seg_dec;

    assign w_tmo_hit   = (r_tmo == TW'(TIMEOUT_CYC - 1));
    assign bus.tx_valid = (r_state == S_SEND);
    assign bus.tx_data  = r_tx_data;
    assign o_busy       = (r_state != S_IDLE);
    assign o_err        = r_err;
    assign o_seg        = r_seg;
    assign o_an         = r_an;

    // Classify the incoming byte as a hex digit and extract its value.
    always_comb begin
        w_is_hex = 1'b1;
        w_nib    = 4'h0;
        if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39)
            w_nib = bus.rx_data[3:0];
        else if ((bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) ||
                 (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66))
            w_nib = bus.rx_data[3:0] + 4'd9;
        else
            w_is_hex = 1'b0;
    end

    // Parser state register.
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nx;
    end

    // Parser next-state and datapath controls; any reply funnels into SEND.
    always_comb begin
        w_state_nx = r_state;
        w_send     = 1'b0;
        w_ack      = 8'h00;
        w_tmo_clr  = 1'b0;
        w_start    = 1'b0;
        w_need     = 3'd0;
        w_shift    = 1'b0;
        w_commit   = 1'b0;
        w_cmd_ld   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    w_cmd_ld = 1'b1;
                    if (bus.rx_data == CH_D) begin
                        w_state_nx = S_GET_HEX;
                        w_start    = 1'b1;
                        w_need     = 3'd4;
                        w_tmo_clr  = 1'b1;
                    end else if (bus.rx_data == CH_B) begin
                        w_state_nx = S_GET_HEX;
                        w_start    = 1'b1;
                        w_need     = 3'd1;
                        w_tmo_clr  = 1'b1;
                    end else if (bus.rx_data == CH_C) begin
                        w_state_nx = S_GET_LF;
                        w_tmo_clr  = 1'b1;
                    end else if (bus.rx_data != CH_LF && bus.rx_data != CH_CR) begin
                        w_send = 1'b1;
                        w_ack  = CH_E;
                    end
                end
            end
            S_GET_HEX: begin
                if (bus.rx_valid) begin
                    w_tmo_clr = 1'b1;
                    if (w_is_hex) begin
                        w_shift = 1'b1;
                        if (r_left == 3'd1) w_state_nx = S_GET_LF;
                    end else begin
                        w_send = 1'b1;
                        w_ack  = CH_E;
                    end
                end else if (w_tmo_hit) begin
                    w_send = 1'b1;
                    w_ack  = CH_E;
                end
            end
            S_GET_LF: begin
                if (bus.rx_valid) begin
                    w_tmo_clr = 1'b1;
                    w_send    = 1'b1;
                    if (bus.rx_data == CH_LF) begin
                        w_commit = 1'b1;
                        w_ack    = CH_K;
                    end else begin
                        w_ack    = CH_E;
                    end
                end else if (w_tmo_hit) begin
                    w_send = 1'b1;
                    w_ack  = CH_E;
                end
            end
            S_SEND: begin
                if (bus.tx_ready) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
        if (w_send) w_state_nx = S_SEND;
    end

    // Command datapath: staging, timeout, reply byte and committed buffers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cmd     <= 8'h00;
            r_left    <= 3'd0;
            r_stage   <= 16'h0000;
            r_tmo     <= '0;
            r_tx_data <= 8'h00;
            r_err     <= 1'b0;
            r_disp    <= 16'h0000;
            r_bright  <= 4'hF;
        end else begin
            if (w_cmd_ld) r_cmd <= bus.rx_data;
            if (w_start) begin
                r_stage <= 16'h0000;
                r_left  <= w_need;
            end else if (w_shift) begin
                r_stage <= {r_stage[11:0], w_nib};
                r_left  <= r_left - 3'd1;
            end
            // Only runs while waiting for more of a command.
            if (w_tmo_clr || (r_state != S_GET_HEX && r_state != S_GET_LF))
                r_tmo <= '0;
            else
                r_tmo <= r_tmo + TW'(1);
            if (w_send) r_tx_data <= w_ack;
            r_err <= w_send && (w_ack == CH_E);
            if (w_commit) begin
                if (r_cmd == CH_D)      r_disp   <= r_stage;
                else if (r_cmd == CH_B) r_bright <= r_stage[3:0];
                else if (r_cmd == CH_C) r_disp   <= 16'h0000;
            end
        end
    end

    assign w_sel_nib = r_disp[{r_dig, 2'b00} +: 4];

    // Hex digit to segment pattern {g,f,e,d,c,b,a}.
    always_comb begin
        w_seg_dec = 7'h00;
        case (w_sel_nib)
            4'h0: w_seg_dec = 7'h3F;
            4'h1: w_seg_dec = 7'h06;
            4'h2: w_seg_dec = 7'h5B;
            4'h3: w_seg_dec = 7'h4F;
            4'h4: w_seg_dec = 7'h66;
            4'h5: w_seg_dec = 7'h6D;
            4'h6: w_seg_dec = 7'h7D;
            4'h7: w_seg_dec = 7'h07;
            4'h8: w_seg_dec = 7'h7F;
            4'h9: w_seg_dec = 7'h6F;
            4'hA: w_seg_dec = 7'h77;
            4'hB: w_seg_dec = 7'h7C;
            4'hC: w_seg_dec = 7'h39;
            4'hD: w_seg_dec = 7'h5E;
            4'hE: w_seg_dec = 7'h79;
            default: w_seg_dec = 7'h71;
        endcase
    end

    // Digit scan, PWM and registered drive so seg/an switch together.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_scan <= '0;
            r_dig  <= 2'd0;
            r_pwm  <= 4'd0;
            r_seg  <= 7'h00;
            r_an   <= 4'hF;
        end else begin
            if (r_scan == SW'(SCAN_DIV - 1)) begin
                r_scan <= '0;
                r_dig  <= r_dig + 2'd1;
            end else begin
                r_scan <= r_scan + SW'(1);
            end
            r_pwm <= r_pwm + 4'd1;
            r_seg <= w_seg_dec;
            r_an  <= (r_pwm < r_bright) ? ~(4'b0001 << r_dig) : 4'hF;
        end
    end
endmodule

// File: tb/tb_seg7_cmd_ctrl.sv
// Directed bench for seg7_cmd_ctrl with a short scan period and timeout.
module tb_seg7_cmd_ctrl;
    localparam int SCAN_DIV    = 4;
    localparam int TIMEOUT_CYC = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       busy;
    logic       err;
    int         n_vec = 0;
    int         n_err = 0;

    seg7_cmd_ctrl_if bus();

    seg7_cmd_ctrl #(.SCAN_DIV(SCAN_DIV), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus),
        .o_seg   (seg),
        .o_an    (an),
        .o_busy  (busy),
        .o_err   (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    // Watch the display for ncyc cycles: segment per lit digit, dark cycles,
    // whether digits advanced strictly 0->1->2->3->0 and seg stayed steady per digit.
    task automatic observe(input int ncyc, output logic [3:0][6:0] segs,
                           output logic [3:0] seen, output int dark,
                           output bit order_ok, output bit steady);
        int prev;
        int d;
        logic [3:0] m;
        prev = -1; segs = '0; seen = 4'h0; dark = 0; order_ok = 1'b1; steady = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            tick();
            if (an == 4'hF) begin
                dark++;
            end else begin
                d = -1;
                for (int i = 0; i < 4; i++) begin
                    m = 4'b0001 << i;
                    if (an == ~m) d = i;
                end
                if (d < 0) begin
                    order_ok = 1'b0;
                end else begin
                    if (!seen[d]) begin
                        seen[d] = 1'b1;
                        segs[d] = seg;
                    end else if (segs[d] !== seg) begin
                        steady = 1'b0;
                    end
                    if (prev >= 0 && d != prev && d != ((prev + 1) % 4)) order_ok = 1'b0;
                    prev = d;
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_vec++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL reset.tx_valid got %b want 0", bus.tx_valid); end
        n_vec++; if (bus.tx_data !== 8'h00) begin n_err++; $display("FAIL reset.tx_data got %h want 00", bus.tx_data); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset.busy got %b want 0", busy); end
        n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL reset.err got %b want 0", err); end
        n_vec++; if (seg !== 7'h00) begin n_err++; $display("FAIL reset.seg got %h want 00", seg); end
        n_vec++; if (an !== 4'hF) begin n_err++; $display("FAIL reset.an got %h want F", an); end
        rst = 1'b0;
        tick();
        n_vec++; if (seg !== 7'h3F) begin n_err++; $display("FAIL reset.first_seg got %h want 3F", seg); end
        n_vec++; if (an !== 4'hE) begin n_err++; $display("FAIL reset.first_an got %h want E", an); end
    endtask

    task automatic test_reject();
        logic [3:0][6:0] segs; logic [3:0] seen; int dark; bit ord; bit st;
        send_str("D12");
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL reject.busy got %b want 1", busy); end
        send_byte("G");
        n_vec++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h45) begin n_err++; $display("FAIL reject.ack got v=%b d=%h want v=1 d=45", bus.tx_valid, bus.tx_data); end
        n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL reject.err got %b want 1", err); end
        tick();
        n_vec++; if (err !== 1'b0 || bus.tx_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL reject.after got err=%b v=%b busy=%b want 0 0 0", err, bus.tx_valid, busy); end
        // Line endings in IDLE are ignored, any other stray byte is rejected.
        send_byte(8'h0D);
        n_vec++; if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL reject.cr got v=%b busy=%b err=%b want 0 0 0", bus.tx_valid, busy, err); end
        send_byte("X");
        n_vec++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h45 || err !== 1'b1) begin n_err++; $display("FAIL reject.stray got v=%b d=%h err=%b want 1 45 1", bus.tx_valid, bus.tx_data, err); end
        tick();
        observe(64, segs, seen, dark, ord, st);
        n_vec++; if (segs !== {4{7'h3F}} || seen !== 4'hF) begin n_err++; $display("FAIL reject.display got %h seen %h want 3F3F3F3F seen F", segs, seen); end
    endtask

    task automatic test_digits();
        logic [3:0][6:0] segs; logic [3:0] seen; int dark; bit ord; bit st;
        send_str("D1A2F");
        n_vec++; if (bus.tx_valid !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL digits.pre_lf got v=%b busy=%b want 0 1", bus.tx_valid, busy); end
        send_byte(8'h0A);
        n_vec++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h4B || err !== 1'b0) begin n_err++; $display("FAIL digits.ack got v=%b d=%h err=%b want 1 4B 0", bus.tx_valid, bus.tx_data, err); end
        tick();
        n_vec++; if (bus.tx_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL digits.idle got v=%b busy=%b want 0 0", bus.tx_valid, busy); end
        observe(64, segs, seen, dark, ord, st);
        n_vec++; if (segs !== {7'h06, 7'h77, 7'h5B, 7'h71} || seen !== 4'hF) begin n_err++; $display("FAIL digits.segs got %h seen %h want 06 77 5B 71", segs, seen); end
        n_vec++; if (dark !== 4) begin n_err++; $display("FAIL digits.dark got %0d want 4", dark); end
        n_vec++; if (!ord || !st) begin n_err++; $display("FAIL digits.scan got order=%b steady=%b want 1 1", ord, st); end
    endtask

    task automatic test_brightness();
        logic [3:0][6:0] segs; logic [3:0] seen; int dark; bit ord; bit st;
        send_str("B0\n");
        n_vec++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h4B) begin n_err++; $display("FAIL bright0.ack got v=%b d=%h want 1 4B", bus.tx_valid, bus.tx_data); end
        tick();
        observe(64, segs, seen, dark, ord, st);
        n_vec++; if (dark !== 64) begin n_err++; $display("FAIL bright0.dark got %0d want 64", dark); end
        send_str("B8\n");
        n_vec++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h4B) begin n_err++; $display("FAIL bright8.ack got v=%b d=%h want 1 4B", bus.tx_valid, bus.tx_data); end
        tick();
        observe(16, segs, seen, dark, ord, st);
        n_vec++; if (dark !== 8) begin n_err++; $display("FAIL bright8.dark16 got %0d want 8", dark); end
        observe(64, segs, seen, dark, ord, st);
        n_vec++; if (dark !== 32) begin n_err++; $display("FAIL bright8.dark64 got %0d want 32", dark); end
        send_str("Bf\n");
        n_vec++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h4B) begin n_err++; $display("FAIL brightf.ack got v=%b d=%h want 1 4B", bus.tx_valid, bus.tx_data); end
        tick();
        observe(64, segs, seen, dark, ord, st);
        n_vec++; if (dark !== 4) begin n_err++; $display("FAIL brightf.dark got %0d want 4", dark); end
    endtask

    task automatic test_timeout();
        logic [3:0][6:0] segs; logic [3:0] seen; int dark; bit ord; bit st;
        int n;
        send_str("D12");
        n = 0;
        while (bus.tx_valid !== 1'b1 && n < 3 * TIMEOUT_CYC) begin
            tick();
            n++;
        end
        n_vec++; if (n != TIMEOUT_CYC) begin n_err++; $display("FAIL timeout.cycles got %0d want %0d", n, TIMEOUT_CYC); end
        n_vec++; if (bus.tx_data !== 8'h45 || err !== 1'b1) begin n_err++; $display("FAIL timeout.ack got d=%h err=%b want 45 1", bus.tx_data, err); end
        tick();
        send_str("C\n");
        n_vec++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h4B) begin n_err++; $display("FAIL clear.ack got v=%b d=%h want 1 4B", bus.tx_valid, bus.tx_data); end
        tick();
        observe(64, segs, seen, dark, ord, st);
        n_vec++; if (segs !== {4{7'h3F}} || seen !== 4'hF) begin n_err++; $display("FAIL clear.display got %h seen %h want 3F3F3F3F", segs, seen); end
    endtask

    task automatic test_back_to_back();
        logic [3:0][6:0] segs; logic [3:0] seen; int dark; bit ord; bit st;
        bit stable;
        string extra;
        int extra_tx;
        extra = "D0000\n";
        bus.tx_ready = 1'b0;
        send_str("D9999\n");
        n_vec++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h4B) begin n_err++; $display("FAIL stall.ack got v=%b d=%h want 1 4B", bus.tx_valid, bus.tx_data); end
        stable = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (c % 2 == 0) send_byte(extra[(c / 2) % 6]);
            else tick();
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h4B || busy !== 1'b1) stable = 1'b0;
        end
        n_vec++; if (!stable) begin n_err++; $display("FAIL stall.hold got stable=%b want 1", stable); end
        bus.tx_ready = 1'b1;
        tick();
        n_vec++; if (bus.tx_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL stall.release got v=%b busy=%b want 0 0", bus.tx_valid, busy); end
        extra_tx = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (bus.tx_valid === 1'b1) extra_tx++;
        end
        n_vec++; if (extra_tx != 0) begin n_err++; $display("FAIL stall.single got %0d extra valid cycles want 0", extra_tx); end
        observe(64, segs, seen, dark, ord, st);
        n_vec++; if (segs !== {4{7'h6F}} || seen !== 4'hF) begin n_err++; $display("FAIL stall.display got %h seen %h want 6F6F6F6F", segs, seen); end
    endtask

    task automatic test_mid_reset();
        logic [3:0][6:0] segs; logic [3:0] seen; int dark; bit ord; bit st;
        int stray;
        send_str("B8\n");
        tick();
        send_str("DAB");
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst.busy got %b want 1", busy); end
        rst = 1'b1;
        tick();
        n_vec++; if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || an !== 4'hF || seg !== 7'h00) begin n_err++; $display("FAIL midrst.during got v=%b busy=%b an=%h seg=%h want 0 0 F 00", bus.tx_valid, busy, an, seg); end
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (bus.tx_valid === 1'b1) stray++;
        end
        n_vec++; if (stray != 0) begin n_err++; $display("FAIL midrst.no_ack got %0d valid cycles want 0", stray); end
        observe(64, segs, seen, dark, ord, st);
        n_vec++; if (segs !== {4{7'h3F}} || seen !== 4'hF || dark !== 4) begin n_err++; $display("FAIL midrst.buffers got %h dark %0d want 3F3F3F3F dark 4", segs, dark); end
        send_str("DABCD\n");
        n_vec++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h4B) begin n_err++; $display("FAIL midrst.ack got v=%b d=%h want 1 4B", bus.tx_valid, bus.tx_data); end
        tick();
        observe(64, segs, seen, dark, ord, st);
        n_vec++; if (segs !== {7'h77, 7'h7C, 7'h39, 7'h5E} || !ord) begin n_err++; $display("FAIL midrst.display got %h order %b want 77 7C 39 5E", segs, ord); end
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.tx_ready = 1'b1;
        test_reset();
        test_reject();
        test_digits();
        test_brightness();
        test_timeout();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
